dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory-side end of the core's data-memory valid/ready protocol.
//  Accepts one load/store request at a time from the core, commits stores with byte lanes,
//  returns read data after a programmable wait. Sits between the core and on-chip data RAM.
// PARAMETERS
//  DATAWIDTH   32            data/address width
//  ADDR_WORDS  1024          RAM depth in 32-bit words (power of two)
//  LATENCY     1             read wait cycles, 0..15
//  BASE_ADDR   32'h0000_0000 byte address of word 0
// PORTS
//  DMEM_Clk_In            in   1   clock, all logic on rising edge
//  DMEM_Reset_In          in   1   synchronous reset, active-high
//  DMEM_Req_Valid_In      in   1   request valid (core data-mem valid out)
//  DMEM_Req_Ready_Out     out  1   request accepted when Valid&&Ready (core data-mem ready in)
//  DMEM_Req_Write_In      in   1   1=store, 0=load (core store indication)
//  DMEM_Addr_InBUS        in   32  byte address; [1:0] ignored
//  DMEM_Byteenable_InBUS  in   4   store byte lanes; ignored on loads
//  DMEM_Writedata_InBUS   in   32  store data, lane-aligned
//  DMEM_Rsp_Valid_Out     out  1   read data valid (core data-mem valid in)
//  DMEM_Rsp_Ready_In      in   1   core accepts read data (core data-mem ready out)
//  DMEM_Readdata_OutBUS   out  32  full read word; core's LSU extracts bytes
//  DMEM_Error_Out         out  1   only with DMEM_RANGE_CHECK_EN
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE, Rsp_Valid_Out=0, Readdata=0, Error_Out=0,
//   Req_Ready_Out=0 while reset high, 1 from first cycle after release. RAM not cleared.
//  States IDLE / WAIT / RESP; Req_Ready_Out=1 only in IDLE (and not in reset).
//  IDLE, accept (Valid&&Ready) in cycle N: latch addr, write flag, counter<=LATENCY.
//   Store: RAM lanes with be=1 written at end of N; stay IDLE; no response phase. be=0000 -> no change.
//   Load, LATENCY=0: RAM read at end of N into Readdata, -> RESP.
//   Load, LATENCY>0: -> WAIT.
//  WAIT: counter==1 -> RAM read into Readdata, -> RESP; else counter--. Req valid/data ignored.
//  Rsp_Valid_Out first high in cycle N+1+LATENCY.
//  RESP: Rsp_Valid_Out=1, Readdata stable until Rsp_Ready_In=1; then -> IDLE, Valid low next cycle.
//   Next accept earliest the cycle after the response handshake (one outstanding load max).
//  Index = (Addr-BASE_ADDR)>>2, truncated to log2(ADDR_WORDS) bits (wraps modulo depth).
//  Reset mid-operation: pending load abandoned, no response; store at same edge as reset dropped.
//  Req_Valid_In high while Ready low: no effect, request must be held by core.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR+4*ADDR_WORDS) ->
//   store dropped, load returns 32'h0 with normal timing, DMEM_Error_Out pulses 1 cycle at N+1.
//  Not defined: no DMEM_Error_Out port, no comparator, index wraps as above.
// STRUCTURE
//  Package dmem_pkg: state codes IDLE/WAIT/RESP, counter width (4), index-width clog2 function.
//  Sub-module dmem_ram_array: single-port synchronous RAM, 4 byte-lane write enables, registered read.
//  Top holds FSM, wait counter, request latches, range check.
// TESTING
//  1 LATENCY=1: store 0xDEADBEEF @0x10 be=1111, load 0x10 accepted cycle N -> Rsp_Valid at N+2, data 0xDEADBEEF.
//  2 store 0x0000AA00 @0x10 be=0010, load 0x10 -> 0xDEADAAEF; store be=0000 -> word unchanged.
//  3 Rsp_Ready_In low 5 cycles in RESP -> Rsp_Valid and data held, Req_Ready_Out=0 throughout.
//  4 reset pulse while in WAIT -> no Rsp_Valid, Req_Ready_Out=1 cycle after release, @0x10 still 0xDEADAAEF.
//  5 store 0x12345678 @0x1010 (ADDR_WORDS=1024): no macro -> load 0x10 returns 0x12345678;
//    macro on -> Error_Out pulse, load 0x1010 returns 0x0, @0x10 unchanged.
//  6 LATENCY=0 and LATENCY=15: Rsp_Valid at N+1 and N+16; back-to-back loads accepted 1 cycle after handshake.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared types and helpers for the data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Brief    : Core <-> data-memory request/response bundle.
//             DMEM_RANGE_CHECK_EN adds the error strobe.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int DATAWIDTH = 32
);
    logic                     DMEM_Req_Valid_In;
    logic                     DMEM_Req_Ready_Out;
    logic                     DMEM_Req_Write_In;
    logic [DATAWIDTH-1:0]     DMEM_Addr_InBUS;
    logic [DATAWIDTH/8-1:0]   DMEM_Byteenable_InBUS;
    logic [DATAWIDTH-1:0]     DMEM_Writedata_InBUS;
    logic                     DMEM_Rsp_Valid_Out;
    logic                     DMEM_Rsp_Ready_In;
    logic [DATAWIDTH-1:0]     DMEM_Readdata_OutBUS;
`ifdef DMEM_RANGE_CHECK_EN
    logic                     DMEM_Error_Out;

    modport master (
        output DMEM_Req_Valid_In, DMEM_Req_Write_In, DMEM_Addr_InBUS,
               DMEM_Byteenable_InBUS, DMEM_Writedata_InBUS, DMEM_Rsp_Ready_In,
        input  DMEM_Req_Ready_Out, DMEM_Rsp_Valid_Out, DMEM_Readdata_OutBUS,
               DMEM_Error_Out
    );
    modport slave (
        input  DMEM_Req_Valid_In, DMEM_Req_Write_In, DMEM_Addr_InBUS,
               DMEM_Byteenable_InBUS, DMEM_Writedata_InBUS, DMEM_Rsp_Ready_In,
        output DMEM_Req_Ready_Out, DMEM_Rsp_Valid_Out, DMEM_Readdata_OutBUS,
               DMEM_Error_Out
    );
`else
    modport master (
        output DMEM_Req_Valid_In, DMEM_Req_Write_In, DMEM_Addr_InBUS,
               DMEM_Byteenable_InBUS, DMEM_Writedata_InBUS, DMEM_Rsp_Ready_In,
        input  DMEM_Req_Ready_Out, DMEM_Rsp_Valid_Out, DMEM_Readdata_OutBUS
    );
    modport slave (
        input  DMEM_Req_Valid_In, DMEM_Req_Write_In, DMEM_Addr_InBUS,
               DMEM_Byteenable_InBUS, DMEM_Writedata_InBUS, DMEM_Rsp_Ready_In,
        output DMEM_Req_Ready_Out, DMEM_Rsp_Valid_Out, DMEM_Readdata_OutBUS
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_ram_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ram_array
//  Brief    : Single-port synchronous RAM, byte-lane writes, registered read.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_ram_array #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int AW        = 10
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   we_i,
    input  wire logic [DATAWIDTH/8-1:0] be_i,
    input  wire logic [AW-1:0]          addr_i,
    input  wire logic [DATAWIDTH-1:0]   wdata_i,
    input  wire logic                   re_i,
    output logic      [DATAWIDTH-1:0]   rdata_o
);

    localparam int BEW = DATAWIDTH / 8;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BEW; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Memory-side end of the core data-memory valid/ready protocol.
//             Optional range check enabled by DMEM_RANGE_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                   DATAWIDTH  = 32,
    parameter int                   ADDR_WORDS = 1024,
    parameter int                   LATENCY    = 1,
    parameter logic [DATAWIDTH-1:0] BASE_ADDR  = '0
) (
    input  wire logic        DMEM_Clk_In,
    input  wire logic        DMEM_Reset_In,
    dmem_responder_if.slave  bus
);

    localparam int              AW    = idx_width(ADDR_WORDS);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [AW-1:0]    idx_q,   idx_d;

    logic [DATAWIDTH-1:0] w_off;
    logic [AW-1:0]        w_bus_idx;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_ram_we;
    logic                 w_ram_re;
    logic [DATAWIDTH-1:0] w_ram_rdata;

    assign w_off     = bus.DMEM_Addr_InBUS - BASE_ADDR;
    assign w_bus_idx = w_off[AW+1:2];
    assign w_ready   = (state_q == ST_IDLE) && !DMEM_Reset_In;
    assign w_accept  = bus.DMEM_Req_Valid_In && w_ready;

`ifdef DMEM_RANGE_CHECK_EN
    localparam longint unsigned SPAN = 64'(ADDR_WORDS) * 64'd4;

    logic w_oor;
    logic err_q;
    logic zero_q;

    // Unsigned offset compare also catches addresses below BASE_ADDR via wrap.
    assign w_oor    = 64'(w_off) >= SPAN;
    assign w_ram_we = w_accept && bus.DMEM_Req_Write_In && !w_oor;

    always_ff @(posedge DMEM_Clk_In) begin
        if (DMEM_Reset_In) begin
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            err_q <= w_accept && w_oor;
            if (w_accept && !bus.DMEM_Req_Write_In) begin
                zero_q <= w_oor;
            end
        end
    end

    assign bus.DMEM_Error_Out       = err_q;
    assign bus.DMEM_Readdata_OutBUS = zero_q ? '0 : w_ram_rdata;
`else
    assign w_ram_we                 = w_accept && bus.DMEM_Req_Write_In;
    assign bus.DMEM_Readdata_OutBUS = w_ram_rdata;
`endif

    always_ff @(posedge DMEM_Clk_In) begin
        if (DMEM_Reset_In) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        w_ram_re = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    idx_d = w_bus_idx;
                    cnt_d = LAT_C;
                    if (!bus.DMEM_Req_Write_In) begin
                        if (LAT_C == '0) begin
                            w_ram_re = 1'b1;
                            state_d  = ST_RESP;
                        end else begin
                            state_d  = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    w_ram_re = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.DMEM_Rsp_Ready_In) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.DMEM_Req_Ready_Out = w_ready;
    assign bus.DMEM_Rsp_Valid_Out = (state_q == ST_RESP);

    dmem_ram_array #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (ADDR_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk_i   (DMEM_Clk_In),
        .rst_i   (DMEM_Reset_In),
        .we_i    (w_ram_we),
        .be_i    (bus.DMEM_Byteenable_InBUS),
        .addr_i  ((state_q == ST_IDLE) ? w_bus_idx : idx_q),
        .wdata_i (bus.DMEM_Writedata_InBUS),
        .re_i    (w_ram_re),
        .rdata_o (w_ram_rdata)
    );

endmodule
`default_nettype wire
